// File: rtl/sipo_frame_ctrl.sv
// Framed serial receiver: start bit, WIDTH data bits (MSB first), optional even parity, stop bit,
// then valid/ready hand-off of the word. Define PARITY_CHECK_EN to add the parity bit check.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data,
  input  logic             en,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_r;
  state_t             state_next_s;
  logic [WIDTH-1:0]   shift_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   q_r;
  logic               q_valid_r;
  logic               busy_r;
  logic               frame_err_r;
  logic               overrun_r;
  logic               parity_err_r;
  logic               par_mis_s;
  logic               load_s;
  logic               xfer_s;
  logic               frame_err_s;
  logic               overrun_s;
  logic               parity_err_s;

`ifdef PARITY_CHECK_EN
  logic par_err_r;

  function automatic logic parity_bad(input logic [WIDTH-1:0] word, input logic pbit);
    return (^word) ^ pbit;
  endfunction

  // Latch the parity verdict; cleared whenever a new frame starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err_r <= 1'b0;
    end else if (en && state_r == ST_IDLE) begin
      par_err_r <= 1'b0;
    end else if (en && state_r == ST_PARITY) begin
      par_err_r <= parity_bad(shift_r, data);
    end else begin
      par_err_r <= par_err_r;
    end
  end

  assign par_mis_s = par_err_r;
`else
  assign par_mis_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state; only bit strobes move the frame forward.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en && !data) state_next_s = ST_SHIFT;
        else             state_next_s = ST_IDLE;
      end
      ST_SHIFT: begin
        if (en && cnt_r == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
          state_next_s = ST_PARITY;
`else
          state_next_s = ST_STOP;
`endif
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_PARITY: begin
        if (en) state_next_s = ST_STOP;
        else    state_next_s = ST_PARITY;
      end
      ST_STOP: begin
        if (en) state_next_s = ST_IDLE;
        else    state_next_s = ST_STOP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Stop-bit outcome and handshake decode; error priority is frame, then parity, then overrun.
  always_comb begin
    load_s       = 1'b0;
    frame_err_s  = 1'b0;
    overrun_s    = 1'b0;
    parity_err_s = 1'b0;
    xfer_s       = q_valid_r & out_ready;
    if (en && state_r == ST_STOP) begin
      if (!data) begin
        frame_err_s = 1'b1;
      end else if (par_mis_s) begin
        parity_err_s = 1'b1;
      end else if (q_valid_r && !out_ready) begin
        overrun_s = 1'b1;
      end else begin
        load_s = 1'b1;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else if (en) begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        ST_SHIFT: begin
          shift_r <= {shift_r[WIDTH-2:0], data};
          cnt_r   <= cnt_r + CNT_W'(1);
        end
        default: begin
          shift_r <= shift_r;
          cnt_r   <= cnt_r;
        end
      endcase
    end else begin
      shift_r <= shift_r;
      cnt_r   <= cnt_r;
    end
  end

  // Output word, valid flag and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r          <= {WIDTH{1'b0}};
      q_valid_r    <= 1'b0;
      busy_r       <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      if (load_s) begin
        q_r       <= shift_r;
        q_valid_r <= 1'b1;
      end else if (xfer_s) begin
        q_valid_r <= 1'b0;
      end else begin
        q_valid_r <= q_valid_r;
      end
      busy_r       <= (state_next_s != ST_IDLE);
      frame_err_r  <= frame_err_s;
      overrun_r    <= overrun_s;
      parity_err_r <= parity_err_s;
    end
  end

  assign q          = q_r;
  assign q_valid    = q_valid_r;
  assign busy       = busy_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign parity_err = parity_err_r;

endmodule
